// File: rtl/operand_bram_loader.sv
// Write-side loader for operand Memory-A/Memory-B: accepts (A, B) pairs on a valid/ready
// stream and writes them at consecutive addresses, optionally zero-padding a short load.
module operand_bram_loader #(
    parameter int DEPTH     = 32,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int ZERO_FILL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_last,
    output logic              ena_A,
    output logic              wea_A,
    output logic [ADDR_W-1:0] addra_A,
    output logic [DATA_W-1:0] dina_A,
    output logic              ena_B,
    output logic              wea_B,
    output logic [ADDR_W-1:0] addra_B,
    output logic [DATA_W-1:0] dina_B,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_ready;
    logic                w_accept;
    logic                w_at_last;

    logic                r_wr;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_dina_a;
    logic [DATA_W-1:0]   r_dina_b;
    logic [ADDR_W:0]     r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = (r_state == S_LOAD);
        w_accept    = w_ready && in_valid;
        w_at_last   = (r_ptr == LAST_ADDR);
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    if (w_at_last) begin
                        w_state_nxt = S_DONE;
                    end else if (in_last) begin
                        w_state_nxt = (ZERO_FILL != 0) ? S_FILL : S_DONE;
                    end
                end
            end
            // Leave FILL in the same cycle the last zero write is registered, so
            // load_done coincides with the address DEPTH-1 strobe.
            S_FILL: begin
                if (w_at_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The pointer saturates at DEPTH-1; in FILL it already points one past the last data word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr     <= 1'b0;
            r_ptr    <= '0;
            r_addr   <= '0;
            r_dina_a <= '0;
            r_dina_b <= '0;
            r_count  <= '0;
        end else begin
            r_wr <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_ptr   <= '0;
                        r_count <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_wr     <= 1'b1;
                        r_addr   <= r_ptr;
                        r_dina_a <= in_a;
                        r_dina_b <= in_b;
                        r_count  <= r_count + CNT_ONE;
                        if (!w_at_last) begin
                            r_ptr <= r_ptr + ADDR_ONE;
                        end
                    end
                end
                S_FILL: begin
                    r_wr     <= 1'b1;
                    r_addr   <= r_ptr;
                    r_dina_a <= '0;
                    r_dina_b <= '0;
                    if (!w_at_last) begin
                        r_ptr <= r_ptr + ADDR_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = w_ready;
    assign ena_A      = r_wr;
    assign wea_A      = r_wr;
    assign ena_B      = r_wr;
    assign wea_B      = r_wr;
    assign addra_A    = r_addr;
    assign addra_B    = r_addr;
    assign dina_A     = r_dina_a;
    assign dina_B     = r_dina_b;
    assign load_done  = (r_state == S_DONE);
    assign word_count = r_count;

endmodule

// File: tb/tb_operand_bram_loader.sv
// Randomized bench for operand_bram_loader: a zero-fill and a no-fill instance share one
// stimulus stream and are compared each cycle against a transaction-level reference model.
module tb_operand_bram_loader;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, in_valid, in_last;
    logic [DW-1:0] in_a, in_b;

    logic [1:0]    rdy, ena, wea, enb, web, done;
    logic [AW-1:0] adra [2];
    logic [AW-1:0] adrb [2];
    logic [DW-1:0] da   [2];
    logic [DW-1:0] db   [2];
    logic [AW:0]   wc   [2];

    operand_bram_loader #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .ZERO_FILL(1)) dut_f (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .ena_A(ena[0]), .wea_A(wea[0]), .addra_A(adra[0]), .dina_A(da[0]),
        .ena_B(enb[0]), .wea_B(web[0]), .addra_B(adrb[0]), .dina_B(db[0]),
        .load_done(done[0]), .word_count(wc[0])
    );

    operand_bram_loader #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .ZERO_FILL(0)) dut_n (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .ena_A(ena[1]), .wea_A(wea[1]), .addra_A(adra[1]), .dina_A(da[1]),
        .ena_B(enb[1]), .wea_B(web[1]), .addra_B(adrb[1]), .dina_B(db[1]),
        .load_done(done[1]), .word_count(wc[1])
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0=idle 1=loading 2=padding 3=done; m_cnt pairs taken so far,
    // m_rem zero words still owed. The write seen after an edge is whatever the model issued.
    int            m_ph  [2];
    int            m_cnt [2];
    int            m_rem [2];
    logic          m_en  [2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_da  [2];
    logic [DW-1:0] m_db  [2];
    logic [DW-1:0] exp_ma[2][DEPTH];
    logic [DW-1:0] exp_mb[2][DEPTH];
    logic [DW-1:0] cap_ma[2][DEPTH];
    logic [DW-1:0] cap_mb[2][DEPTH];

    task automatic model_write(input int z, input int addr, input logic [DW-1:0] a,
                               input logic [DW-1:0] b);
        m_en[z]         = 1'b1;
        m_addr[z]       = AW'(addr);
        m_da[z]         = a;
        m_db[z]         = b;
        exp_ma[z][addr] = a;
        exp_mb[z][addr] = b;
    endtask

    task automatic model_step(input int z);
        m_en[z] = 1'b0;
        if (rst) begin
            m_ph[z]   = 0;
            m_cnt[z]  = 0;
            m_rem[z]  = 0;
            m_addr[z] = '0;
            m_da[z]   = '0;
            m_db[z]   = '0;
        end else if (m_ph[z] == 0 || m_ph[z] == 3) begin
            if (start) begin
                m_ph[z]  = 1;
                m_cnt[z] = 0;
            end
        end else if (m_ph[z] == 1) begin
            if (in_valid) begin
                model_write(z, m_cnt[z], in_a, in_b);
                m_cnt[z]++;
                if (m_cnt[z] == DEPTH) begin
                    m_ph[z] = 3;
                end else if (in_last) begin
                    if (z == 0) begin
                        m_rem[z] = DEPTH - m_cnt[z];
                        m_ph[z]  = 2;
                    end else begin
                        m_ph[z] = 3;
                    end
                end
            end
        end else begin
            model_write(z, DEPTH - m_rem[z], '0, '0);
            m_rem[z]--;
            if (m_rem[z] == 0) m_ph[z] = 3;
        end
    endtask

    task automatic cycle();
        for (int z = 0; z < 2; z++) model_step(z);
        @(posedge clk);
        #1;
        for (int z = 0; z < 2; z++) begin
            check($sformatf("in_ready[%0d]", z), 64'(rdy[z]), 64'(m_ph[z] == 1));
            check($sformatf("ena_A[%0d]", z), 64'(ena[z]), 64'(m_en[z]));
            check($sformatf("wea_A[%0d]", z), 64'(wea[z]), 64'(m_en[z]));
            check($sformatf("ena_B[%0d]", z), 64'(enb[z]), 64'(m_en[z]));
            check($sformatf("wea_B[%0d]", z), 64'(web[z]), 64'(m_en[z]));
            check($sformatf("addra_A[%0d]", z), 64'(adra[z]), 64'(m_addr[z]));
            check($sformatf("addra_B[%0d]", z), 64'(adrb[z]), 64'(m_addr[z]));
            check($sformatf("dina_A[%0d]", z), 64'(da[z]), 64'(m_da[z]));
            check($sformatf("dina_B[%0d]", z), 64'(db[z]), 64'(m_db[z]));
            check($sformatf("load_done[%0d]", z), 64'(done[z]), 64'(m_ph[z] == 3));
            check($sformatf("word_count[%0d]", z), 64'(wc[z]), 64'(m_cnt[z]));
            if (ena[z] === 1'b1 && wea[z] === 1'b1) begin
                cap_ma[z][adra[z]] = da[z];
                cap_mb[z][adra[z]] = db[z];
            end
        end
    endtask

    task automatic mem_check();
        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < DEPTH; i++) begin
                check($sformatf("memA[%0d][%0d]", z, i), 64'(cap_ma[z][i]), 64'(exp_ma[z][i]));
                check($sformatf("memB[%0d][%0d]", z, i), 64'(cap_mb[z][i]), 64'(exp_mb[z][i]));
            end
        end
    endtask

    initial begin
        for (int z = 0; z < 2; z++) begin
            m_ph[z] = 0; m_cnt[z] = 0; m_rem[z] = 0; m_en[z] = 1'b0;
            m_addr[z] = '0; m_da[z] = '0; m_db[z] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                exp_ma[z][i] = '0; exp_mb[z][i] = '0;
                cap_ma[z][i] = '0; cap_mb[z][i] = '0;
            end
        end
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Full load; start arrives with in_valid already high, so that pair is refused.
        start = 1'b1; in_valid = 1'b1; in_a = 32'hdead_beef; in_b = 32'hfeed_f00d;
        cycle();
        start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_a = DW'(i); in_b = DW'(2 * i); in_valid = 1'b1; in_last = 1'b0;
            cycle();
        end
        in_valid = 1'b0;
        repeat (3) cycle();
        mem_check();

        // Short load of 5 started from DONE.
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_a = $urandom; in_b = $urandom; in_valid = 1'b1; in_last = (i == 4);
            cycle();
        end
        in_valid = 1'b0; in_last = 1'b0;
        repeat (30) cycle();
        mem_check();

        // Gapped input with stray start pulses during the load.
        start = 1'b1;
        cycle();
        for (int i = 0; i < 40; i++) begin
            in_valid = (i % 3 == 0); start = (i % 3 == 1);
            in_a = $urandom; in_b = $urandom; in_last = (i == 36);
            cycle();
        end
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        repeat (30) cycle();
        mem_check();

        // Reset after 10 accepts, then reload from address 0.
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_a = $urandom; in_b = $urandom; in_valid = 1'b1;
            cycle();
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0; in_valid = 1'b0;
        cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_a = $urandom; in_b = $urandom; in_valid = 1'b1; in_last = (i == 19);
            cycle();
        end
        in_valid = 1'b0; in_last = 1'b0;
        repeat (15) cycle();
        mem_check();

        // Free-running random traffic including occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(99) == 0);
            start    = ($urandom_range(15) == 0);
            in_valid = 1'($urandom_range(1));
            in_last  = ($urandom_range(7) == 0);
            in_a     = $urandom;
            in_b     = $urandom;
            cycle();
        end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        repeat (35) cycle();
        mem_check();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/operand_bram_loader.md
# operand_bram_loader

Write-side front end for the operand memories. Accepts a valid/ready stream of (A, B) operand pairs and writes them into BRAM Memory-A and Memory-B at consecutive addresses through their write ports. Signals completion so the BRAM read controller can begin streaming operands into the 32x32 multiplier. Runs in the divided-clock domain shared by the memories and controller.

## Interface
- DEPTH, 32, words per memory; also the address wrap point
- ADDR_W, 5, address width; equals log2(DEPTH)
- DATA_W, 32, operand width
- ZERO_FILL, 1, when 1, a short load pads the remaining addresses with zeros
- clk  input  1  single clock, the divided clock (clk_div_1 domain); all logic rising-edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load from address 0
- in_valid  input  1  operand pair valid
- in_ready  output  1  loader can accept a pair
- in_a  input  DATA_W  operand for Memory-A
- in_b  input  DATA_W  operand for Memory-B
- in_last  input  1  marks the final pair of a load; qualified by in_valid
- ena_A, wea_A  output  1 each  Memory-A enable/write-enable
- addra_A  output  ADDR_W  Memory-A address
- dina_A  output  DATA_W  Memory-A write data
- ena_B, wea_B  output  1 each  Memory-B enable/write-enable; always equal to ena_A/wea_A
- addra_B  output  ADDR_W  always equal to addra_A
- dina_B  output  DATA_W  Memory-B write data
- load_done  output  1  high while in DONE
- word_count  output  ADDR_W+1  pairs accepted in the current or most recent load

## Operation
- States: IDLE, LOAD, FILL, DONE. Reset sends the block to IDLE.
- IDLE or DONE, start=1: go to LOAD. Clear the address pointer and word_count to 0.
- LOAD: in_ready=1. An accept is a cycle with in_valid && in_ready. On each accept:
  - register a write strobe: ena=wea=1, addr=pointer, dina_A=in_a, dina_B=in_b
  - increment the pointer and word_count
- Leaving LOAD:
  - accept at address DEPTH-1, with or without in_last: go to DONE
  - accept with in_last at address k<DEPTH-1: go to FILL if ZERO_FILL=1, otherwise DONE
- FILL: in_ready=0. Writes zero to both memories at addresses k+1 through DEPTH-1, one per cycle. After the DEPTH-1 write, go to DONE. word_count does not change.
- DONE: in_ready=0, load_done=1. Holds until start.
- start is ignored in LOAD and FILL.
- in_valid outside LOAD is ignored and has no side effects.
- The pointer never exceeds DEPTH-1. There is no wrap within a load; a new load restarts at 0.
- Reset at any time, including mid-LOAD or mid-FILL:
  - next cycle: all strobes 0, state IDLE
  - already-written memory contents are not erased

## Timing
- Reset values: in_ready=0, ena/wea=0, addr=0, dina=0, load_done=0, word_count=0.
- Write latency is 1 cycle. An accept in cycle t produces the strobe in cycle t+1. Strobes are single-cycle and driven from registers.
- Throughput is one pair per cycle with in_valid held high.
- When no write is issued: ena=wea=0, and addr/dina hold their last values.
- start in cycle t: in_ready=1 from cycle t+1.
- Final accept in cycle t, with no FILL:
  - cycle t+1: final strobe and load_done=1
  - the controller may start reads from t+2
- Final accept at address k in cycle t, with FILL:
  - cycle t+1: strobe for address k
  - cycles t+2 through t+1+(DEPTH-1-k): zero strobes for addresses k+1 through DEPTH-1
  - load_done=1 in the cycle of the final zero strobe
- start together with in_valid in IDLE: that pair is not accepted, because in_ready is still 0.

## Test plan
- Full load: start, then 32 back-to-back pairs (a=i, b=2i), no in_last -> 32 strobes at addresses 0..31 in consecutive cycles, each one cycle after its accept; load_done rises with the address-31 strobe; word_count=32.
- Short load, ZERO_FILL=1: 5 pairs with in_last on the 5th -> addresses 0..4 carry the data, then 27 zero writes at 5..31; in_ready=0 during FILL; load_done with the address-31 strobe; word_count=5.
- Short load, ZERO_FILL=0: 5 pairs with in_last -> only 5 strobes; load_done in the cycle of the address-4 strobe.
- Gapped input: in_valid toggling 1,0,0,1,… -> strobes only after accepts; addresses contiguous; start pulses during LOAD ignored.
- Reset mid-load after 10 accepts -> the next cycle shows IDLE, all outputs at reset values; a following start reloads from address 0.
- Restart from DONE: start in DONE -> word_count clears to 0, a new load runs, load_done drops the cycle after start.
